memory_r1_up_access: RTL

Access controller on the driving side of the long tank upper half: generates the serial memory input bit and the tank gating strobes (clear/in/out) and recovers the serial memory output bit.
Turns parallel short-word read/write requests into bit-serial transfers timed to the tank's circulation (32 minor cycles × 18 digit periods = 576 digit periods, 1.152 ms).
Sits between the store-access sequencer and the tank.

---
 rtl/memory_r1_up_access_if.sv | 23 ++
 rtl/memory_r1_up_access.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/memory_r1_up_access_if.sv
// rtl/memory_r1_up_access_if.sv - request/response bus between store-access sequencer and tank access controller
interface memory_r1_up_access_if #(
  parameter int ADDR_W    = 5,
  parameter int WORD_BITS = 17
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [ADDR_W-1:0]    req_addr;
  logic [WORD_BITS-1:0] req_wdata;
  logic                 rsp_valid;
  logic [WORD_BITS-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/memory_r1_up_access.sv
// rtl/memory_r1_up_access.sv - bit-serial short-word access to the long tank upper half
// Strobes are registered from the next-cycle state so they line up with the digit counter.
module memory_r1_up_access #(
  parameter int WORD_BITS    = 17,
  parameter int DIGITS       = 18,
  parameter int MINOR_CYCLES = 32,
  parameter int ADDR_W       = 5
) (
  input  logic                  r1_clk,
  input  logic                  r1_rst,
  input  logic                  major_sync,
  memory_r1_up_access_if.slave  bus,
  output logic                  r1_up_mib,
  output logic                  r1_up_t1_clr,
  output logic                  r1_up_t1_in,
  output logic                  r1_up_t1_out,
  input  logic                  r1_up_mob_t1,
  output logic                  busy
);
  localparam int DIGIT_W = $clog2(DIGITS);
  localparam logic [DIGIT_W-1:0] LAST_DIGIT  = DIGIT_W'(DIGITS - 1);
  localparam logic [DIGIT_W-1:0] DATA_DIGITS = DIGIT_W'(WORD_BITS);
  localparam logic [ADDR_W-1:0]  LAST_MINOR  = ADDR_W'(MINOR_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT_SLOT, XFER} state_t;

  state_t               state_q, state_d;
  logic [DIGIT_W-1:0]   digit_q, digit_d, cur_digit;
  logic [ADDR_W-1:0]    minor_q, minor_d, cur_minor;
  logic                 write_q, write_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [WORD_BITS-1:0] wdata_q, wdata_d;
  logic [WORD_BITS-1:0] acc_q, acc_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [WORD_BITS-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                 mib_q, mib_d;
  logic                 clr_q, clr_d;
  logic                 in_q, in_d;
  logic                 out_q, out_d;
  logic                 handshake, slot_next, xfer_next, data_digit;

  always_comb begin
    // major_sync makes the current cycle minor 0 digit 0
    cur_digit = major_sync ? '0 : digit_q;
    cur_minor = major_sync ? '0 : minor_q;
    digit_d   = cur_digit + 1'b1;
    minor_d   = cur_minor;
    if (cur_digit == LAST_DIGIT) begin
      digit_d = '0;
      minor_d = (cur_minor == LAST_MINOR) ? '0 : cur_minor + 1'b1;
    end

    handshake = bus.req_valid && (state_q == IDLE);
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    if (handshake) begin
      write_d = bus.req_write;
      addr_d  = bus.req_addr;
      wdata_d = bus.req_wdata;
    end

    slot_next   = (minor_d == addr_d) && (digit_d == '0);
    state_d     = state_q;
    acc_d       = acc_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (handshake) state_d = slot_next ? XFER : WAIT_SLOT;
      end
      WAIT_SLOT: begin
        if (slot_next) state_d = XFER;
      end
      XFER: begin
        if (major_sync) begin
          state_d = WAIT_SLOT;
        end else begin
          if (!write_q && (digit_q < DATA_DIGITS)) begin
            acc_d = (acc_q & ~(WORD_BITS'(1) << digit_q))
                  | (WORD_BITS'(r1_up_mob_t1) << digit_q);
          end
          if (digit_q == LAST_DIGIT) begin
            state_d     = IDLE;
            rsp_valid_d = 1'b1;
            if (!write_q) rsp_rdata_d = acc_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Writes hold clr/in through the gap digit so it is rewritten as 0
    xfer_next  = (state_d == XFER);
    data_digit = (digit_d < DATA_DIGITS);
    mib_d = xfer_next && write_d && data_digit && |(wdata_d & (WORD_BITS'(1) << digit_d));
    clr_d = xfer_next && write_d;
    in_d  = xfer_next && write_d;
    out_d = xfer_next && !write_d && data_digit;
  end

  always_ff @(posedge r1_clk) begin
    if (r1_rst) begin
      state_q     <= IDLE;
      digit_q     <= '0;
      minor_q     <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      acc_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      mib_q       <= 1'b0;
      clr_q       <= 1'b0;
      in_q        <= 1'b0;
      out_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      digit_q     <= digit_d;
      minor_q     <= minor_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      acc_q       <= acc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      mib_q       <= mib_d;
      clr_q       <= clr_d;
      in_q        <= in_d;
      out_q       <= out_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign busy          = (state_q != IDLE);
  assign r1_up_mib     = mib_q;
  assign r1_up_t1_clr  = clr_q;
  assign r1_up_t1_in   = in_q;
  assign r1_up_t1_out  = out_q;
endmodule
